// File: rtl/regbank_reader.sv
// regbank_reader: eight-entry register bank with reg8bit-style writes and a handshaked burst reader.
// Optional macro REGBANK_BYPASS_EN forwards a same-cycle write into the FETCH capture.

module regbank_reader #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] datain,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW-1:0]    rd_len,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] dataout,
  output logic             rd_last,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] bank [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    left;
  logic [WIDTH-1:0] fetch_data;

`ifdef REGBANK_BYPASS_EN
  // A write landing on the register being fetched is forwarded so the beat sees the new value.
  always_comb begin
    fetch_data = bank[ptr];
    if (enable && (wr_addr == ptr)) begin
      fetch_data = datain;
    end
  end
`else
  always_comb begin
    fetch_data = bank[ptr];
  end
`endif

  assign busy = (state != IDLE);

  // Writes run every cycle regardless of the reader; ptr wraps naturally at AW bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
      state    <= IDLE;
      ptr      <= '0;
      left     <= '0;
      dataout  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (enable) begin
        bank[wr_addr] <= datain;
      end
      case (state)
        IDLE: begin
          if (rd_req) begin
            ptr   <= rd_addr;
            left  <= rd_len;
            state <= FETCH;
          end
        end
        FETCH: begin
          dataout  <= fetch_data;
          rd_valid <= 1'b1;
          rd_last  <= (left == '0);
          state    <= HOLD;
        end
        HOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (left != '0) begin
              ptr   <= ptr + 1'b1;
              left  <= left - 1'b1;
              state <= FETCH;
            end else begin
              rd_last <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
